// File: rtl/core_div_unit.sv
// ---------------------------------------------------------------------------
// core_div_unit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   One operation in flight at a time. A normal divide produces one
//   quotient bit per cycle, MSB first. Divide-by-zero and signed overflow
//   (MIN_INT / -1) are resolved when the request is accepted.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   kill         synchronous flush: abort the in-flight op and drop its result
//   req_valid    request present
//   req_ready    unit can accept a request (high only while idle)
//   req_op       00=DIV, 01=DIVU, 10=REM, 11=REMU
//   req_a        dividend
//   req_b        divisor
//   resp_valid   result valid, held until resp_ready
//   resp_ready   consumer accepts the result
//   resp_result  quotient (DIV/DIVU) or remainder (REM/REMU)
// ---------------------------------------------------------------------------
module core_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            kill,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_reg, state_next;
   logic [CW-1:0]   counter_reg;
   logic            is_rem_reg;
   logic            q_neg_reg;
   logic            r_neg_reg;
   // Holds the dividend magnitude; quotient bits shift in from the LSB as
   // dividend bits shift out of the MSB, so it ends up holding the quotient.
   logic [XLEN-1:0] dividend_reg;
   logic [XLEN-1:0] divisor_reg;
   // The running remainder is always below the divisor, so XLEN bits are
   // enough to store it; only the shifted trial value needs XLEN+1 bits.
   logic [XLEN-1:0] rem_reg;

   // ---------------- request decode (used only on the accept edge) --------
   logic            signed_op;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_by_zero;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] special_result;

   always_comb begin
      signed_op      = ~req_op[0];
      a_neg          = signed_op & req_a[XLEN-1];
      b_neg          = signed_op & req_b[XLEN-1];
      // abs(MIN_INT) wraps back to MIN_INT, which is the correct unsigned
      // magnitude, so no extra case is needed here.
      a_mag          = a_neg ? (~req_a + 1'b1) : req_a;
      b_mag          = b_neg ? (~req_b + 1'b1) : req_b;
      div_by_zero    = (req_b == '0);
      overflow       = signed_op && (req_a == MIN_INT) && (req_b == '1);
      special        = div_by_zero | overflow;
      if (div_by_zero) begin
         special_result = req_op[1] ? req_a : '1;
      end else begin
         special_result = req_op[1] ? '0 : MIN_INT;
      end
   end

   // ---------------- one restoring step ----------------------------------
   logic [XLEN:0]   r_shift;
   logic [XLEN:0]   r_diff;
   logic            q_bit;
   logic [XLEN-1:0] rem_step;
   logic [XLEN-1:0] q_step;
   logic            last_step;
   logic [XLEN-1:0] final_result;

   always_comb begin
      r_shift   = {rem_reg, dividend_reg[XLEN-1]};
      r_diff    = r_shift - {1'b0, divisor_reg};
      q_bit     = (r_shift >= {1'b0, divisor_reg});
      rem_step  = q_bit ? r_diff[XLEN-1:0] : r_shift[XLEN-1:0];
      q_step    = {dividend_reg[XLEN-2:0], q_bit};
      last_step = (counter_reg == CW'(XLEN-1));
      // Sign correction folded into the final step so the result register
      // is already correct on the cycle DONE is entered.
      if (is_rem_reg) begin
         final_result = r_neg_reg ? (~rem_step + 1'b1) : rem_step;
      end else begin
         final_result = q_neg_reg ? (~q_step + 1'b1) : q_step;
      end
   end

   // ---------------- FSM ------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // kill overrides every other transition, including an accept.
      if (kill) begin
         state_next = IDLE;
      end
   end

   // ---------------- datapath -------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         counter_reg  <= '0;
         is_rem_reg   <= 1'b0;
         q_neg_reg    <= 1'b0;
         r_neg_reg    <= 1'b0;
         dividend_reg <= '0;
         divisor_reg  <= '0;
         rem_reg      <= '0;
         resp_result  <= '0;
      end else if (kill) begin
         counter_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  is_rem_reg   <= req_op[1];
                  q_neg_reg    <= a_neg ^ b_neg;
                  r_neg_reg    <= a_neg;
                  dividend_reg <= a_mag;
                  divisor_reg  <= b_mag;
                  rem_reg      <= '0;
                  counter_reg  <= '0;
                  if (special) begin
                     resp_result <= special_result;
                  end
               end
            end
            CALC: begin
               dividend_reg <= q_step;
               rem_reg      <= rem_step;
               counter_reg  <= counter_reg + 1'b1;
               if (last_step) begin
                  resp_result <= final_result;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_div_unit.sv
module tb_core_div_unit;

   localparam logic [31:0] MIN_INT = 32'h8000_0000;
   localparam logic [1:0]  OP_DIV  = 2'b00;
   localparam logic [1:0]  OP_DIVU = 2'b01;
   localparam logic [1:0]  OP_REM  = 2'b10;
   localparam logic [1:0]  OP_REMU = 2'b11;

   logic        clk;
   logic        rst;
   logic        kill;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;

   int n_checks = 0;
   int n_pass   = 0;

   core_div_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .kill        (kill),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RV32M semantics written directly from the ISA rules.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        r;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         r = op[1] ? a : 32'hFFFF_FFFF;
      end else if (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF) begin
         r = op[1] ? 32'd0 : MIN_INT;
      end else begin
         case (op)
            OP_DIV:  r = sa / sb;
            OP_DIVU: r = a / b;
            OP_REM:  r = sa % sb;
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF);
   endfunction

   // Rising edges after the accept edge before resp_valid is seen:
   // normal divides take 32, special cases are visible straight after the
   // accept edge (valid in the very next cycle).
   function automatic int exp_edges(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return is_special(op, a, b) ? 0 : 32;
   endfunction

   // ---------------- cycle-level compare process -------------------------
   bit          m_busy = 1'b0;
   int          m_wait = 0;
   logic [31:0] m_exp  = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_busy = 1'b0;
            m_wait = 0;
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst_resp_result", resp_result, 32'd0);
            chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
         end else begin
            chk("mon_req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
            chk("mon_resp_valid", {31'd0, resp_valid}, {31'd0, (m_busy && m_wait == 0)});
            if (m_busy && m_wait == 0) begin
               chk("mon_resp_result", resp_result, m_exp);
            end
            // what the coming rising edge does
            if (kill) begin
               m_busy = 1'b0;
            end else if (!m_busy) begin
               if (req_valid) begin
                  m_busy = 1'b1;
                  m_exp  = model(req_op, req_a, req_b);
                  m_wait = exp_edges(req_op, req_a, req_b);
               end
            end else if (m_wait != 0) begin
               m_wait--;
            end else if (resp_ready) begin
               m_busy = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus --------------------------------------------
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit use_lit, input logic [31:0] lit);
      int          n;
      logic [31:0] exp;
      exp = model(op, a, b);
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_op     = op;
      req_a      = a;
      req_b      = b;
      resp_ready = (stall == 0);
      n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", {31'd0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      // operands may change freely once accepted
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      req_op    = 2'($urandom);
      n = 0;
      while (!resp_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!resp_valid) begin
         chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
         resp_ready = 1'b1;
         return;
      end
      chk("latency", n, exp_edges(op, a, b));
      chk("result", resp_result, exp);
      if (use_lit) begin
         chk("result_lit", resp_result, lit);
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("hold_result", resp_result, exp);
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_req_ready", {31'd0, req_ready}, 32'd1);
      $display("op=%0d a=0x%08h b=0x%08h result=0x%08h edges=%0d", op, a, b, exp, n);
   endtask

   initial begin
      bit          seen;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;

      rst        = 1'b1;
      kill       = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // hand-computed expectations
      run_op(OP_DIV,  32'd100,        32'd7,          0, 1'b1, 32'd14);
      run_op(OP_REM,  32'hFFFF_FFF9,  32'd2,          0, 1'b1, 32'hFFFF_FFFF);
      run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          0, 1'b1, 32'hFFFF_FFFD);
      run_op(OP_REMU, 32'd7,          32'hFFFF_FFFF,  0, 1'b1, 32'd7);
      run_op(OP_DIVU, 32'd5,          32'd0,          0, 1'b1, 32'hFFFF_FFFF);
      run_op(OP_REM,  32'd5,          32'd0,          0, 1'b1, 32'd5);
      run_op(OP_DIV,  MIN_INT,        32'hFFFF_FFFF,  0, 1'b1, MIN_INT);
      run_op(OP_REM,  MIN_INT,        32'hFFFF_FFFF,  0, 1'b1, 32'd0);
      run_op(OP_DIVU, MIN_INT,        32'hFFFF_FFFF,  0, 1'b1, 32'd0);
      run_op(OP_DIV,  32'hFFFF_FF9C,  32'd7,          10, 1'b1, 32'hFFFF_FFF2);

      // randomized operations
      for (int t = 0; t < 150; t++) begin
         op  = 2'($urandom);
         sel = $urandom_range(0, 7);
         a   = $urandom;
         b   = $urandom;
         case (sel)
            0: b = 32'd0;
            1: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
            2: begin
               a = $urandom_range(0, 300);
               b = $urandom_range(1, 20);
               if ($urandom_range(0, 1) == 1) a = -a;
               if ($urandom_range(0, 1) == 1) b = -b;
            end
            3: b = $urandom_range(1, 9);
            default: ;
         endcase
         run_op(op, a, b, $urandom_range(0, 3), 1'b0, 32'd0);
      end

      // kill during CALC, with a new request presented in the kill cycle
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = OP_DIV;
      req_a     = 32'd1000;
      req_b     = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      kill      = 1'b1;
      req_valid = 1'b1;
      req_a     = 32'd50;
      req_b     = 32'd0;
      @(posedge clk); #1;
      kill      = 1'b0;
      req_valid = 1'b0;
      chk("kill_req_ready", {31'd0, req_ready}, 32'd1);
      chk("kill_resp_valid", {31'd0, resp_valid}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      chk("kill_no_resp", {31'd0, seen}, 32'd0);
      $display("kill during CALC: resp_seen=%0d", seen);

      // reset mid-CALC; resp_result holds 14 beforehand
      run_op(OP_DIV, 32'd100, 32'd7, 0, 1'b1, 32'd14);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = OP_DIVU;
      req_a     = 32'd12345;
      req_b     = 32'd11;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("async_rst_resp_result", resp_result, 32'd0);
      chk("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
      $display("reset mid-CALC: resp_valid=%0d resp_result=0x%08h", resp_valid, resp_result);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFD);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
